// File: rtl/bsg_imul_pkg.sv
// Shared types for the iterative integer multiplier: operation codes and FSM states.
package bsg_imul_pkg;

  typedef enum logic [1:0] {
    eMul    = 2'b00,
    eMulh   = 2'b01,
    eMulhsu = 2'b10,
    eMulhu  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    eIdle = 2'b00,
    eBusy = 2'b01,
    eFix  = 2'b10,
    eDone = 2'b11
  } state_e;

endpackage

// File: rtl/bsg_imul_iter_if.sv
// Request/response handshake bundle of bsg_imul_iter; master is the requester.
interface bsg_imul_iter_if #(parameter int width_p = 32);
  logic               v_i;
  logic               ready_o;
  logic [1:0]         op_i;
  logic [width_p-1:0] opA_i;
  logic [width_p-1:0] opB_i;
  logic               v_o;
  logic               ready_i;
  logic [width_p-1:0] result_o;

  modport master (
    output v_i, op_i, opA_i, opB_i, ready_i,
    input  ready_o, v_o, result_o
  );

  modport slave (
    input  v_i, op_i, opA_i, opB_i, ready_i,
    output ready_o, v_o, result_o
  );
endinterface

// File: rtl/bsg_imul_slice_mul.sv
// Combinational unsigned width_p x slice_p partial-product multiplier.
module bsg_imul_slice_mul #(
  parameter int width_p = 32,
  parameter int slice_p = 8
) (
  input  logic [width_p-1:0]         a,
  input  logic [slice_p-1:0]         b,
  output logic [width_p+slice_p-1:0] prod
);

  assign prod = {{slice_p{1'b0}}, a} * {{width_p{1'b0}}, b};

endmodule

// File: rtl/bsg_imul_iter.sv
// Iterative signed/unsigned multiplier, one multiplier slice per cycle.
// Optional BSG_IMUL_ZERO_SKIP_EN ends the slice loop early once the remaining multiplier slices are zero.
//
// state | meaning
// eIdle | waiting for a request, ready_o high
// eBusy | accumulating one partial product per cycle
// eFix  | applying the result sign to the accumulator
// eDone | result valid, held until ready_i
module bsg_imul_iter
  import bsg_imul_pkg::*;
#(
  parameter int width_p = 32,
  parameter int slice_p = 8
) (
  input  logic            clk_i,
  input  logic            reset_i,
  bsg_imul_iter_if.slave  io
);

  localparam int n_slices = width_p / slice_p;
  localparam int acc_w    = 2 * width_p;
  localparam int cnt_w    = (n_slices > 1) ? $clog2(n_slices) : 1;
  localparam int sh_w     = $clog2(acc_w);
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(n_slices - 1);

  state_e               state_r;
  op_e                  op_r;
  logic                 neg_r;
  logic [width_p-1:0]   mag_a_r;
  logic [width_p-1:0]   mag_b_r;
  logic [acc_w-1:0]     acc_r;
  logic [cnt_w-1:0]     cnt_r;
  logic [sh_w-1:0]      sh_r;

  op_e                  op_in;
  logic                 sign_a;
  logic                 sign_b;
  logic [width_p-1:0]   mag_a_in;
  logic [width_p-1:0]   mag_b_in;
  logic [width_p+slice_p-1:0] prod;
  logic                 last_slice;

  always_comb begin
    op_in    = op_e'(io.op_i);
    sign_a   = ((op_in == eMulh) || (op_in == eMulhsu)) && io.opA_i[width_p-1];
    sign_b   = (op_in == eMulh) && io.opB_i[width_p-1];
    mag_a_in = sign_a ? -io.opA_i : io.opA_i;
    mag_b_in = sign_b ? -io.opB_i : io.opB_i;
  end

  bsg_imul_slice_mul #(
    .width_p (width_p),
    .slice_p (slice_p)
  ) u_slice_mul (
    .a    (mag_a_r),
    .b    (mag_b_r[slice_p-1:0]),
    .prod (prod)
  );

  // mag_b_r is shifted down each cycle, so its upper part is exactly the unprocessed slices
`ifdef BSG_IMUL_ZERO_SKIP_EN
  assign last_slice = (cnt_r == last_cnt) || ((mag_b_r >> slice_p) == '0);
`else
  assign last_slice = (cnt_r == last_cnt);
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= eIdle;
      op_r    <= eMul;
      neg_r   <= 1'b0;
      mag_a_r <= '0;
      mag_b_r <= '0;
      acc_r   <= '0;
      cnt_r   <= '0;
      sh_r    <= '0;
    end else begin
      case (state_r)
        eIdle: begin
          if (io.v_i) begin
            state_r <= eBusy;
            op_r    <= op_in;
            neg_r   <= sign_a ^ sign_b;
            mag_a_r <= mag_a_in;
            mag_b_r <= mag_b_in;
            acc_r   <= '0;
            cnt_r   <= '0;
            sh_r    <= '0;
          end
        end
        eBusy: begin
          acc_r   <= acc_r + (acc_w'(prod) << sh_r);
          mag_b_r <= mag_b_r >> slice_p;
          cnt_r   <= cnt_r + cnt_w'(1);
          sh_r    <= sh_r + sh_w'(slice_p);
          if (last_slice) state_r <= eFix;
        end
        eFix: begin
          if (neg_r) acc_r <= -acc_r;
          state_r <= eDone;
        end
        eDone: begin
          if (io.ready_i) state_r <= eIdle;
        end
        default: state_r <= eIdle;
      endcase
    end
  end

  assign io.ready_o  = (state_r == eIdle);
  assign io.v_o      = (state_r == eDone);
  assign io.result_o = (op_r == eMul) ? acc_r[width_p-1:0] : acc_r[acc_w-1:width_p];

endmodule

// File: doc/bsg_imul_iter.md
BSG_IMUL_ITER -- requirements
Module: bsg_imul_iter

Interface
REQ-001 The block SHALL provide parameter width_p, default 32, meaning operand and result width in bits.
REQ-002 The block SHALL provide parameter slice_p, default 8, meaning multiplier-slice width; width_p % slice_p == 0; N = width_p/slice_p.
REQ-003 Port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset_i  input  1  synchronous, active-high reset.
REQ-005 Port v_i  input  1  request valid.
REQ-006 Port ready_o  output  1  block accepts a request this cycle.
REQ-007 Port op_i  input  2  operation: 00 MUL (low), 01 MULH (s*s), 10 MULHSU (s*u), 11 MULHU (u*u).
REQ-008 Port opA_i  input  width_p  multiplicand.
REQ-009 Port opB_i  input  width_p  multiplier.
REQ-010 Port v_o  output  1  result valid.
REQ-011 Port ready_i  input  1  consumer accepts result.
REQ-012 Port result_o  output  width_p  low or high half of the 2*width_p product, per op.

Function
REQ-013 Accept SHALL occur when v_i & ready_o; op, signs and operand magnitudes SHALL be latched on accept; inputs are don't-care otherwise.
REQ-014 Signedness: opA signed for MULH/MULHSU; opB signed for MULH only; MUL result is sign-independent.
REQ-015 Latched magnitudes SHALL be unsigned width_p bits (|-2^(width_p-1)| representable); neg_r = signA XOR signB.
REQ-016 States SHALL be eIdle, eBusy, eFix, eDone; ready_o = (state == eIdle); v_o = (state == eDone).
REQ-017 eIdle -> eBusy on accept; slice counter and 2*width_p accumulator cleared.
REQ-018 eBusy: each cycle, acc += (magA * magB[k*slice_p +: slice_p]) << (k*slice_p), k = 0..N-1; after k = N-1, -> eFix.
REQ-019 eFix: if neg_r, acc <= -acc (two's complement, 2*width_p bits); -> eDone.
REQ-020 eDone: result_o = acc[width_p-1:0] for MUL, else acc[2*width_p-1:width_p]; result_o held stable while v_o & !ready_i; -> eIdle on ready_i.
REQ-021 Latency: accept at cycle 0, v_o first high at cycle N+2 (default 6); no new accept until the cycle after result handshake.
REQ-022 result_o SHALL equal the exact 2*width_p product half for all operand values including most-negative and zero.

Reset
REQ-023 reset_i SHALL force eIdle, clear the accumulator, counter and neg_r; v_o = 0, ready_o = 1 the cycle after reset deasserts.
REQ-024 reset_i asserted mid-operation (eBusy/eFix/eDone) SHALL abandon the operation without producing v_o.

Configuration
REQ-025 Macro BSG_IMUL_ZERO_SKIP_EN defined: in eBusy, when all remaining magB slices (k..N-1) are zero, the block SHALL go directly to eFix that cycle; result is unchanged, latency = (index of highest nonzero slice + 1) + 2, minimum 3 (magB == 0).
REQ-026 Macro undefined: fixed latency N+2 for every operation.

Structure
REQ-027 Shared package bsg_imul_pkg SHALL hold the op enum (eMul, eMulh, eMulhsu, eMulhu) and the state enum.
REQ-028 The width_p x slice_p unsigned partial multiplier SHALL be sub-module bsg_imul_slice_mul (combinational, 2 parameters).

Verification (width_p=32, slice_p=8)
REQ-029 MULH 0x80000000 * 0x80000000 -> result_o 0x40000000, v_o at cycle 6 (skip disabled).
REQ-030 MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF; MULHU same -> 0xFFFFFFFE; MUL same -> 0x00000001.
REQ-031 Hold ready_i low 5 cycles in eDone -> v_o and result_o stable, ready_o low; accept blocked until handshake.
REQ-032 Assert reset_i in eBusy cycle 2 -> v_o never asserted; next request 7*9 MUL -> 63.
REQ-033 With BSG_IMUL_ZERO_SKIP_EN: MULHU 0x12345678 * 0x00000003 -> 0x00000000, v_o at cycle 3; opB 0 -> cycle 3; opB 0x01000000 -> cycle 6.
REQ-034 Random 10^5 ops all modes, random ready_i stalls -> match reference 64-bit product model.
